sample_clk_gen: RTL and testbench
=================================

// Module: sample_clk_gen
// PURPOSE
//   Runtime-programmable sample-clock generator for the FFT capture path.
//   - Divides clk by a loadable half-period to produce sample_clk, plus a one-cycle sample_en strobe.
//   - Counts samples into frames of FRAME_LEN points and flags frame start/end for the FFT input buffer.
//   - Divisor changes and start/stop are glitch-free: applied only at period boundaries.
// PARAMETERS
//   CNT_W        16     width of the divisor and half-period counter
//   DEFAULT_DIV  6103   half-period (clk cycles) after reset; 6103 -> 4096 Hz at 50 MHz
//   MIN_DIV      2      smallest legal half-period; smaller loads are clamped up to this
//   FRAME_LEN    4096   samples per FFT frame; power of two, >=2; IDX_W = $clog2(FRAME_LEN)
// PORTS
//   clk           in   1      system clock
//   rst           in   1      asynchronous reset, active-high
//   enable        in   1      run request; level-sensitive
//   div_in        in   CNT_W  new half-period value
//   div_load      in   1      one-cycle strobe: capture div_in as the pending divisor
//   div_pending   out  1      high while a loaded divisor is waiting to be applied
//   running       out  1      high when the FSM is not in IDLE
//   sample_clk    out  1      divided clock: period 2*div_cur clk cycles, 50% duty
//   sample_en     out  1      one-cycle pulse on the clk edge where sample_clk rises
//   sample_idx    out  IDX_W  index of the sample flagged by the current/last sample_en
//   frame_start   out  1      sample_en && sample_idx==0
//   frame_done    out  1      sample_en && sample_idx==FRAME_LEN-1
// BEHAVIOUR
//   Reset (rst=1, async): state=IDLE, cnt=0, div_cur=DEFAULT_DIV, div_pend=0, div_pending=0;
//     all outputs 0, sample_idx=0.
//   Divisor load: on div_load, div_pend <= max(div_in, MIN_DIV); div_pending <= 1.
//     A second load before apply overwrites (last wins).
//     IDLE: applied on the next cycle (div_cur <= div_pend; div_pending <= 0).
//     RUN/DRAIN: applied only on the edge where sample_clk toggles 0->1; that new period uses the new value.
//     A load in the same cycle as the apply edge: the old pend is applied, the new value stays pending.
//   FSM states IDLE, RUN, DRAIN. Terminal count is tc = (cnt >= div_cur-1); use >=, never ==.
//     IDLE: cnt=0, sample_clk=0, sample_idx=0.
//       enable=1 -> RUN next edge with cnt=0, sample_clk=0.
//       First sample_en comes div_cur cycles after entering RUN.
//     RUN: cnt++ each cycle; on tc, cnt <= 0 and sample_clk toggles.
//       The 0->1 toggle also registers sample_en=1 and advances sample_idx (registered, same edge).
//       enable=0 while sample_clk=0 -> IDLE next edge; no further rise.
//       enable=0 while sample_clk=1 -> DRAIN.
//     DRAIN: keep counting; on tc (1->0 toggle) -> IDLE. sample_clk is never truncated high.
//       enable=1 again -> RUN with no disturbance to cnt or sample_clk.
//   Frame counter: sample_idx=0 for the first sample after IDLE, then +1 per sample_en;
//     wraps to 0 after FRAME_LEN-1. frame_start/frame_done are registered and coincide with sample_en.
//   Outputs are registered; sample_clk is a data signal only (never a clock).
//   Reset mid-operation aborts at once; no partial frame is reported.
// TESTING
//   DEFAULT_DIV=3, FRAME_LEN=4, enable=1 held -> sample_clk period 6 with 3 high;
//     sample_en every 6 cycles, first 3 cycles after RUN entry; idx 0,1,2,3,0; frame_done on idx 3.
//   div_in=0, div_load in IDLE -> div_cur=MIN_DIV=2; sample_clk period 4.
//   RUN at div 3; load 5 mid high-half -> current period completes at 3/3;
//     div_pending clears on the next rise; the following period is 5 high / 5 low.
//   enable drops 1 cycle after a rise -> DRAIN, sample_clk stays high 3 cycles, falls, IDLE, running=0.
//   enable drops in the low half -> IDLE next cycle, no sample_en; re-enable -> sample_idx restarts at 0.
//   rst pulsed mid-frame (idx=2) -> outputs 0 asynchronously, div_cur=DEFAULT_DIV, pending load discarded.

Source files
------------

// File: rtl/sample_clk_gen.sv
// Programmable sample-clock generator for the FFT capture path: divides clk by a
// loadable half-period, strobes sample_en on each rise and tracks frame position.
module sample_clk_gen #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 6103,
  parameter int MIN_DIV     = 2,
  parameter int FRAME_LEN   = 4096,
  localparam int IDX_W      = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_pending,
  output logic             running,
  output logic             sample_clk,
  output logic             sample_en,
  output logic [IDX_W-1:0] sample_idx,
  output logic             frame_start,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] DEF_C    = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, div_cur_q, div_pend_q;
  logic             pend_v_q, sclk_q, sen_q, fs_q, fd_q, running_q;
  logic [IDX_W-1:0] idx_q, nxt_q;

  logic             tc, rise, apply;
  logic [CNT_W-1:0] ld_val, div_cur_d, div_pend_d;
  logic             pend_v_d;

  // A new divisor only takes effect while idle or on a rising edge of sample_clk,
  // so every half-period already in progress runs to its full length.
  always_comb begin
    tc         = (cnt_q >= (div_cur_q - CNT_W'(1)));
    rise       = (state_q == RUN) && enable && !sclk_q && tc;
    apply      = pend_v_q && ((state_q == IDLE) || rise);
    ld_val     = (div_in < MIN_C) ? MIN_C : div_in;
    div_cur_d  = apply ? div_pend_q : div_cur_q;
    div_pend_d = div_load ? ld_val : div_pend_q;
    pend_v_d   = div_load ? 1'b1 : (apply ? 1'b0 : pend_v_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_cur_q  <= DEF_C;
      div_pend_q <= '0;
      pend_v_q   <= 1'b0;
      sclk_q     <= 1'b0;
      sen_q      <= 1'b0;
      fs_q       <= 1'b0;
      fd_q       <= 1'b0;
      running_q  <= 1'b0;
      idx_q      <= '0;
      nxt_q      <= '0;
    end else begin
      div_cur_q  <= div_cur_d;
      div_pend_q <= div_pend_d;
      pend_v_q   <= pend_v_d;
      sen_q      <= 1'b0;
      fs_q       <= 1'b0;
      fd_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          sclk_q <= 1'b0;
          idx_q  <= '0;
          nxt_q  <= '0;
          if (enable) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          if (!enable && !sclk_q) begin
            // Stopping in the low half: leave at once, no further rise.
            state_q   <= IDLE;
            running_q <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            nxt_q     <= '0;
          end else begin
            if (tc) begin
              cnt_q  <= '0;
              sclk_q <= !sclk_q;
              if (!sclk_q) begin
                sen_q <= 1'b1;
                idx_q <= nxt_q;
                fs_q  <= (nxt_q == '0);
                fd_q  <= (nxt_q == LAST_IDX);
                nxt_q <= nxt_q + IDX_W'(1);
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
            // Without enable the high half is finished before returning to idle.
            if (enable) begin
              state_q <= RUN;
            end else if (tc) begin
              state_q   <= IDLE;
              running_q <= 1'b0;
              idx_q     <= '0;
              nxt_q     <= '0;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
      endcase
    end
  end

  assign div_pending = pend_v_q;
  assign running     = running_q;
  assign sample_clk  = sclk_q;
  assign sample_en   = sen_q;
  assign sample_idx  = idx_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;

endmodule

// File: tb/tb_sample_clk_gen.sv
// Bench for sample_clk_gen: directed scenarios plus random enable/load traffic,
// compared each cycle against a half-period countdown model.
module tb_sample_clk_gen;
  localparam int CNT_W = 16, DEF = 3, MIN = 2, FL = 4, IDX_W = 2;

  logic             clk = 1'b0, rst = 1'b1, enable = 1'b0, div_load = 1'b0;
  logic [CNT_W-1:0] div_in = '0;
  logic             div_pending, running, sample_clk, sample_en, frame_start, frame_done;
  logic [IDX_W-1:0] sample_idx;

  sample_clk_gen #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF), .MIN_DIV(MIN), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .div_in(div_in), .div_load(div_load),
    .div_pending(div_pending), .running(running), .sample_clk(sample_clk),
    .sample_en(sample_en), .sample_idx(sample_idx), .frame_start(frame_start),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_err = 0, n_chk = 0, cyc_n = 0;
  int en_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  // Model: on/off, output level, cycles left in the current half, divisors, frame index.
  bit m_on, m_lvl, m_pv, m_sen, m_fs, m_fd;
  int m_left, m_cur, m_pend, m_nxt, m_idx;

  task automatic model_reset();
    m_on = 0; m_lvl = 0; m_pv = 0; m_sen = 0; m_fs = 0; m_fd = 0;
    m_left = 0; m_cur = DEF; m_pend = 0; m_nxt = 0; m_idx = 0;
  endtask

  task automatic model_step(input bit en, input bit ld, input int din);
    bit applied = 0;
    m_sen = 0; m_fs = 0; m_fd = 0;
    if (!m_on) begin
      if (m_pv) begin m_cur = m_pend; applied = 1; end
      m_lvl = 0; m_idx = 0; m_nxt = 0;
      if (en) begin m_on = 1; m_left = m_cur; end
    end else if (!en && !m_lvl) begin
      m_on = 0; m_idx = 0; m_nxt = 0;
    end else if (m_left > 1) begin
      m_left--;
    end else if (!m_lvl) begin
      m_lvl = 1;
      if (m_pv) begin m_cur = m_pend; applied = 1; end
      m_sen = 1; m_idx = m_nxt; m_fs = (m_nxt == 0); m_fd = (m_nxt == FL - 1);
      m_nxt = (m_nxt + 1) % FL;
      m_left = m_cur;
    end else begin
      m_lvl = 0; m_left = m_cur;
      if (!en) begin m_on = 0; m_idx = 0; m_nxt = 0; end
    end
    if (applied) m_pv = 0;
    if (ld) begin m_pend = (din < MIN) ? MIN : din; m_pv = 1; end
  endtask

  task automatic cyc(input bit en, input bit ld, input int din);
    enable = en; div_load = ld; div_in = CNT_W'(din);
    @(posedge clk);
    model_step(en, ld, din);
    @(negedge clk);
    cyc_n++;
    chk("sample_clk", sample_clk, m_lvl);
    chk("sample_en", sample_en, m_sen);
    chk("sample_idx", sample_idx, m_idx);
    chk("frame_start", frame_start, m_fs);
    chk("frame_done", frame_done, m_fd);
    chk("running", running, m_on);
    chk("div_pending", div_pending, m_pv);
    if (sample_en) en_q.push_back(cyc_n);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sclk"}, sample_clk, 0);
    chk({tag, "_sen"}, sample_en, 0);
    chk({tag, "_idx"}, sample_idx, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_fd"}, frame_done, 0);
    chk({tag, "_run"}, running, 0);
    chk({tag, "_pend"}, div_pending, 0);
  endtask

  task automatic chk_gap(input string tag, input int a, input int b, input int exp);
    if (en_q.size() > b) chk(tag, en_q[b] - en_q[a], exp);
    else chk({tag, "_count"}, en_q.size(), b + 1);
  endtask

  initial begin
    int base, hi;
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Default divisor 3: first strobe 3 cycles after RUN entry, then every 6.
    base = cyc_n; en_q.delete();
    repeat (20) cyc(1, 0, 0);
    chk_gap("first_lat", 0, 0, 0);
    if (en_q.size() > 0) chk("first_at", en_q[0] - base, 4);
    chk_gap("period6", 0, 1, 6);
    chk_gap("period6b", 1, 2, 6);

    // Stop in low half, then load 0 while idle -> clamped to 2, period 4.
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    en_q.delete();
    repeat (14) cyc(1, 0, 0);
    chk_gap("period4", 0, 1, 4);

    // Back to 3, then load 5 in the middle of a high half.
    repeat (6) cyc(0, 0, 0);
    cyc(0, 1, 3);
    repeat (2) cyc(0, 0, 0);
    for (int i = 0; i < 20 && !m_sen; i++) cyc(1, 0, 0);
    chk("wait_rise3", m_sen, 1);
    base = cyc_n; en_q.delete();
    cyc(1, 1, 5);
    repeat (30) cyc(1, 0, 0);
    chk_gap("old_period", 0, 0, 0);
    if (en_q.size() > 0) chk("apply_rise", en_q[0] - base, 6);
    chk_gap("period10", 0, 1, 10);

    // Drop enable one cycle after a rise: high half completes (5 cycles).
    for (int i = 0; i < 30 && !m_sen; i++) cyc(1, 0, 0);
    chk("wait_rise5", m_sen, 1);
    hi = sample_clk;
    repeat (12) begin cyc(0, 0, 0); hi += sample_clk; end
    chk("drain_high", hi, 5);
    chk("drain_idle", running, 0);

    // Reset mid-frame with a load pending.
    for (int i = 0; i < 200 && !(m_sen && m_idx == 2); i++) cyc(1, 0, 0);
    chk("wait_idx2", m_idx, 2);
    cyc(1, 1, 7);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    base = cyc_n; en_q.delete();
    repeat (12) cyc(1, 0, 0);
    chk_gap("post_rst", 0, 0, 0);
    if (en_q.size() > 0) chk("post_rst_lat", en_q[0] - base, 4);

    // Random enable toggling and divisor loads.
    begin
      bit en = 1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 29) == 0) en = !en;
        cyc(en, $urandom_range(0, 19) == 0, $urandom_range(0, 7));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
